// File: rtl/enc_pkg.sv
// Shared types and constants for the instruction encoder: request kinds, FSM states,
// opcode prefixes and field bit positions of the decoder's 32-bit instruction word.
package enc_pkg;

  typedef enum logic [2:0] {
    KIND_ALU_IMM = 3'd0,
    KIND_ALU_REG = 3'd1,
    KIND_CMP     = 3'd2,
    KIND_LOAD    = 3'd3,
    KIND_STORE   = 3'd4,
    KIND_BRANCH  = 3'd5,
    KIND_NOP     = 3'd6,
    KIND_HALT    = 3'd7
  } kind_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUN,
    ST_FLUSH,
    ST_DRAIN,
    ST_DONE
  } state_e;

  // Opcode prefix placed in bits [31:29]
  localparam logic [2:0] OP_ALU_IMM = 3'b000;
  localparam logic [2:0] OP_ALU_REG = 3'b010;
  localparam logic [2:0] OP_CMP     = 3'b001;
  localparam logic [2:0] OP_MEM     = 3'b100;
  localparam logic [2:0] OP_BRANCH  = 3'b110;

  localparam int OP_LSB     = 29;
  localparam int CMP_BIT    = 28;
  localparam int FUNC_LSB   = 25;
  localparam int COND_EN_BIT = 26;
  localparam int STORE_BIT  = 25;
  localparam int RD_LSB     = 22;
  localparam int COND_LSB   = 21;
  localparam int RS1_LSB    = 19;
  localparam int RS2_LSB    = 16;
  localparam int IMM_LSB    = 0;

  localparam logic [31:0] NOP_WORD  = 32'hC800_0000;
  localparam logic [31:0] HALT_WORD = 32'hD000_0000;

endpackage

// File: rtl/enc_fifo.sv
// Synchronous DEPTH x WIDTH FIFO with full/empty/count; a push while full is accepted
// when a pop happens in the same cycle. Head reads as zero while empty.
module enc_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; the zeroed head covers the empty case
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/instruction_encoder.sv
// Packs field-level requests into 32-bit instruction words, buffers them and writes them
// to sequential memory addresses, ending each program with HALT. ENC_CHECK_EN enables illegal-request filtering.
module instruction_encoder
  import enc_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic              done,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_kind,
  input  logic [2:0]        in_rd,
  input  logic [2:0]        in_rs1,
  input  logic [2:0]        in_rs2,
  input  logic [2:0]        in_func,
  input  logic              in_cond_en,
  input  logic [3:0]        in_cond,
  input  logic [15:0]       in_imm,
  output logic              mem_we,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              busy,
  output logic              finished,
  output logic              err,
  output logic [ADDR_W:0]   word_count
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  state_e           state;
  state_e           next_state;
  kind_e            kind;
  logic [31:0]      packed_word;
  logic             illegal;
  logic             accept;
  logic             start_fire;
  logic             push_halt;
  logic             fifo_push;
  logic [31:0]      fifo_push_data;
  logic             fifo_pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CNT_W-1:0] fifo_count;

  assign kind       = kind_e'(in_kind);
  assign in_ready   = (state == ST_RUN) & ~fifo_full;
  assign accept     = in_valid & in_ready;
  assign start_fire = start & ((state == ST_IDLE) | (state == ST_DONE));
  assign mem_we     = ~fifo_empty;
  assign fifo_pop   = mem_we & mem_ready;
  assign busy       = (state != ST_IDLE) & (state != ST_DONE);
  assign finished   = (state == ST_DONE);

  always_comb begin
    packed_word = '0;
    packed_word[RD_LSB +: 3]   = in_rd;
    packed_word[RS1_LSB +: 3]  = in_rs1;
    packed_word[RS2_LSB +: 3]  = in_rs2;
    packed_word[IMM_LSB +: 16] = in_imm;
    case (kind)
      KIND_ALU_IMM: begin
        packed_word[OP_LSB +: 3]   = OP_ALU_IMM;
        packed_word[FUNC_LSB +: 3] = in_func;
      end
      KIND_ALU_REG: begin
        packed_word[OP_LSB +: 3]   = OP_ALU_REG;
        packed_word[FUNC_LSB +: 3] = in_func;
      end
      KIND_CMP: begin
        packed_word[OP_LSB +: 3]   = OP_CMP;
        packed_word[CMP_BIT]       = 1'b1;
        packed_word[FUNC_LSB +: 3] = in_func;
      end
      KIND_LOAD: packed_word[OP_LSB +: 3] = OP_MEM;
      KIND_STORE: begin
        packed_word[OP_LSB +: 3] = OP_MEM;
        packed_word[STORE_BIT]   = 1'b1;
      end
      KIND_BRANCH: begin
        packed_word[OP_LSB +: 3]  = OP_BRANCH;
        packed_word[COND_EN_BIT]  = in_cond_en;
        // A conditional branch reuses the register field bits for the condition code
        if (in_cond_en) begin
          packed_word[RS2_LSB +: 9]  = '0;
          packed_word[COND_LSB +: 4] = in_cond;
        end
      end
      KIND_NOP: packed_word = NOP_WORD;
      default:  packed_word = HALT_WORD;
    endcase
  end

`ifdef ENC_CHECK_EN
  logic err_q;

  always_comb begin
    illegal = 1'b0;
    if (kind == KIND_ALU_REG && in_func[2:1] == 2'b00) illegal = 1'b1;
    if (kind == KIND_BRANCH && !in_cond_en && (in_rd != '0 || in_rs1 != '0)) illegal = 1'b1;
    if (kind != KIND_ALU_IMM && kind != KIND_LOAD && kind != KIND_STORE &&
        kind != KIND_BRANCH && in_imm != '0) illegal = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst)                     err_q <= 1'b0;
    else if (start_fire)         err_q <= 1'b0;
    else if (accept && illegal)  err_q <= 1'b1;
  end

  assign err = err_q;
`else
  assign illegal = 1'b0;
  assign err     = 1'b0;
`endif

  always_comb begin
    next_state = state;
    push_halt  = 1'b0;
    case (state)
      ST_IDLE, ST_DONE: if (start) next_state = ST_RUN;
      ST_RUN:           if (done) next_state = ST_FLUSH;
      ST_FLUSH: begin
        if (!fifo_full) begin
          push_halt  = 1'b1;
          next_state = ST_DRAIN;
        end
      end
      // Leave on the last pop itself so finished rises the following cycle
      ST_DRAIN: if (fifo_empty || (fifo_count == CNT_W'(1) && fifo_pop)) next_state = ST_DONE;
      default:  next_state = ST_IDLE;
    endcase
  end

  assign fifo_push      = (accept & ~illegal) | push_halt;
  assign fifo_push_data = push_halt ? HALT_WORD : packed_word;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      mem_addr   <= '0;
      word_count <= '0;
    end else begin
      state <= next_state;
      if (start_fire) begin
        mem_addr   <= start_addr;
        word_count <= '0;
      end else if (fifo_pop) begin
        mem_addr <= mem_addr + 1'b1;
        if (word_count != '1) word_count <= word_count + 1'b1;
      end
    end
  end

  enc_fifo #(
    .DEPTH(DEPTH),
    .WIDTH(32)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (fifo_push),
    .push_data(fifo_push_data),
    .pop      (fifo_pop),
    .head     (mem_wdata),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

endmodule

// File: tb/tb_instruction_encoder.sv
// Scoreboard bench for instruction_encoder: directed and random requests are turned into
// expected memory writes by an arithmetic reference model; a monitor checks every write.
module tb_instruction_encoder;

  localparam int DEPTH  = 4;
  localparam int ADDR_W = 10;
`ifdef ENC_CHECK_EN
  localparam bit CHECK_EN = 1'b1;
`else
  localparam bit CHECK_EN = 1'b0;
`endif

  typedef struct {
    logic [2:0]  kind, rd, rs1, rs2, func;
    logic        cond_en;
    logic [3:0]  cond;
    logic [15:0] imm;
  } req_t;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] start_addr = '0;
  logic              done = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [2:0]        in_kind = '0, in_rd = '0, in_rs1 = '0, in_rs2 = '0, in_func = '0;
  logic              in_cond_en = 1'b0;
  logic [3:0]        in_cond = '0;
  logic [15:0]       in_imm = '0;
  logic              mem_we;
  logic              mem_ready = 1'b0;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              busy, finished, err;
  logic [ADDR_W:0]   word_count;

  exp_t              exp_q[$];
  int                checks = 0;
  int                errors = 0;
  int                prog_words = 0;
  int                ready_mode = 1;
  int                cyc = 0;
  int                last_pop_cyc = 0;
  logic [ADDR_W-1:0] model_addr = '0;
  logic              model_err = 1'b0;
  int                idx;
  bit                took;
  req_t              r;
  req_t              sreq[6];
  exp_t              mon_e;

  instruction_encoder #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .start(start), .start_addr(start_addr), .done(done),
    .in_valid(in_valid), .in_ready(in_ready), .in_kind(in_kind), .in_rd(in_rd),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_func(in_func), .in_cond_en(in_cond_en),
    .in_cond(in_cond), .in_imm(in_imm), .mem_we(mem_we), .mem_ready(mem_ready),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .busy(busy), .finished(finished),
    .err(err), .word_count(word_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Instruction word built from the field layout with plain arithmetic
  function automatic logic [31:0] modelWord(input req_t q);
    logic [31:0] regs_imm;
    regs_imm = 32'(q.rd) * 32'h40_0000 + 32'(q.rs1) * 32'h8_0000 +
               32'(q.rs2) * 32'h1_0000 + 32'(q.imm);
    case (q.kind)
      3'd0: return 32'h0000_0000 + 32'(q.func) * 32'h200_0000 + regs_imm;
      3'd1: return 32'h4000_0000 + 32'(q.func) * 32'h200_0000 + regs_imm;
      3'd2: return 32'h3000_0000 + 32'(q.func) * 32'h200_0000 + regs_imm;
      3'd3: return 32'h8000_0000 + regs_imm;
      3'd4: return 32'h8200_0000 + regs_imm;
      3'd5: return q.cond_en ? (32'hC400_0000 + 32'(q.cond) * 32'h20_0000 + 32'(q.imm))
                             : (32'hC000_0000 + regs_imm);
      3'd6: return 32'hC800_0000;
      default: return 32'hD000_0000;
    endcase
  endfunction

  function automatic bit modelIllegal(input req_t q);
    bit ill;
    ill = (q.kind == 3'd1 && q.func < 3'd2) ||
          (q.kind == 3'd5 && !q.cond_en && (q.rd != 0 || q.rs1 != 0)) ||
          ((q.kind == 3'd1 || q.kind == 3'd2 || q.kind == 3'd6 || q.kind == 3'd7) && q.imm != 0);
    return CHECK_EN && ill;
  endfunction

  function automatic req_t mkReq(input int kind, input int rd, input int rs1, input int rs2,
                                 input int func, input int ce, input int cond, input int imm);
    req_t q;
    q.kind = 3'(kind); q.rd = 3'(rd); q.rs1 = 3'(rs1); q.rs2 = 3'(rs2);
    q.func = 3'(func); q.cond_en = 1'(ce); q.cond = 4'(cond); q.imm = 16'(imm);
    return q;
  endfunction

  function automatic req_t randReq(input bit legal_alu_imm);
    req_t q;
    q.kind    = legal_alu_imm ? 3'd0 : 3'($urandom_range(0, 7));
    q.rd      = 3'($urandom_range(0, 7));
    q.rs1     = 3'($urandom_range(0, 7));
    q.rs2     = 3'($urandom_range(0, 7));
    q.func    = 3'($urandom_range(0, 7));
    q.cond_en = 1'($urandom_range(0, 1));
    q.cond    = 4'($urandom_range(0, 15));
    q.imm     = ($urandom_range(0, 2) == 0) ? 16'h0000 : 16'($urandom);
    return q;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (ready_mode == 2) mem_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic setReady(input int mode);
    ready_mode = mode;
    if (mode < 2) mem_ready = (mode == 1);
  endtask

  task automatic pushExp(input logic [31:0] data);
    exp_q.push_back('{addr: model_addr, data: data});
    model_addr = model_addr + 1'b1;
    prog_words++;
  endtask

  task automatic driveReq(input req_t q);
    in_kind = q.kind; in_rd = q.rd; in_rs1 = q.rs1; in_rs2 = q.rs2; in_func = q.func;
    in_cond_en = q.cond_en; in_cond = q.cond; in_imm = q.imm;
  endtask

  // Offers one request, waits for in_ready, and records what the memory must receive
  task automatic applyStimulus(input req_t q, input bit with_done, input bit use_const,
                               input logic [31:0] const_word);
    int waited = 0;
    driveReq(q);
    in_valid = 1'b1;
    while (!in_ready && waited < 100) begin
      tick();
      waited++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("[TB] FAIL accept_timeout in_ready=0 required=1");
      in_valid = 1'b0;
      return;
    end
    if (with_done) done = 1'b1;
    if (modelIllegal(q)) model_err = 1'b1;
    else pushExp(use_const ? const_word : modelWord(q));
    tick();
    in_valid = 1'b0;
    done     = 1'b0;
    if (with_done) pushExp(32'hD000_0000);
  endtask

  task automatic startProgram(input logic [ADDR_W-1:0] addr);
    start = 1'b1;
    start_addr = addr;
    tick();
    start = 1'b0;
    model_addr = addr;
    model_err  = 1'b0;
    prog_words = 0;
    checkOutput("start_busy", busy, 1);
    checkOutput("start_addr_load", mem_addr, addr);
    checkOutput("start_word_count", word_count, 0);
    checkOutput("start_err_clear", err, 0);
  endtask

  task automatic endProgram();
    done = 1'b1;
    tick();
    done = 1'b0;
    pushExp(32'hD000_0000);
  endtask

  task automatic waitFinished();
    int n = 0;
    while (!finished && n < 300) begin
      tick();
      n++;
    end
    checkOutput("finished", finished, 1);
    checkOutput("finished_latency", 64'(cyc - last_pop_cyc), 1);
    checkOutput("word_count", word_count, 64'(prog_words));
    checkOutput("scoreboard_drained", 64'(exp_q.size()), 0);
    checkOutput("idle_not_busy", busy, 0);
    checkOutput("err_flag", err, model_err);
  endtask

  // Monitor: every accepted memory write must match the oldest expected write
  always @(negedge clk) begin
    if (!rst && mem_we && mem_ready) begin
      last_pop_cyc = cyc;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_write addr=%0h data=%0h required=none", mem_addr, mem_wdata);
      end else begin
        mon_e = exp_q.pop_front();
        checkOutput("write_addr", mem_addr, mon_e.addr);
        checkOutput("write_data", mem_wdata, mon_e.data);
      end
    end
  end

  initial begin
    $display("[TB] instruction_encoder bench, check build=%0d", CHECK_EN);
    setReady(1);
    repeat (3) tick();
    rst = 1'b0;
    tick();
    checkOutput("reset_mem_we", mem_we, 0);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_finished", finished, 0);
    checkOutput("reset_in_ready", in_ready, 0);
    checkOutput("reset_err", err, 0);
    checkOutput("reset_word_count", word_count, 0);
    checkOutput("reset_mem_addr", mem_addr, 0);
    checkOutput("reset_mem_wdata", mem_wdata, 0);

    $display("[TB] directed ALU_IMM program");
    startProgram(10'h010);
    applyStimulus(mkReq(0, 1, 2, 0, 3, 0, 0, 5), 1'b0, 1'b1, 32'h0650_0005);
    endProgram();
    waitFinished();

    $display("[TB] directed STORE/CMP/BRANCH");
    startProgram(10'h020);
    applyStimulus(mkReq(4, 3, 1, 0, 0, 0, 0, 8), 1'b0, 1'b1, 32'h82C8_0008);
    applyStimulus(mkReq(2, 0, 1, 2, 2, 0, 0, 0), 1'b0, 1'b1, 32'h340A_0000);
    applyStimulus(mkReq(5, 0, 0, 0, 0, 1, 4, 16'h0010), 1'b1, 1'b1, 32'hC480_0010);
    waitFinished();

    $display("[TB] random requests with random mem_ready");
    startProgram(10'($urandom_range(0, 1023)));
    setReady(2);
    for (int i = 0; i < 24; i++) begin
      applyStimulus(randReq(1'b0), i == 23, 1'b0, 32'h0);
      if ($urandom_range(0, 3) == 0) tick();
    end
    waitFinished();

    $display("[TB] back-pressure stall");
    setReady(1);
    startProgram(10'h080);
    for (int i = 0; i < 6; i++) sreq[i] = randReq(1'b1);
    setReady(0);
    idx = 0;
    driveReq(sreq[0]);
    in_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      took = in_ready && idx < 6;
      if (took) pushExp(modelWord(sreq[idx]));
      tick();
      if (took) begin
        idx++;
        if (idx < 6) driveReq(sreq[idx]);
      end
      checkOutput("stall_head_data", mem_wdata, exp_q[0].data);
      checkOutput("stall_head_addr", mem_addr, exp_q[0].addr);
    end
    in_valid = 1'b0;
    checkOutput("stall_accepts", 64'(idx), 4);
    checkOutput("stall_in_ready", in_ready, 0);
    checkOutput("stall_mem_we", mem_we, 1);
    setReady(1);
    for (int i = 4; i < 6; i++) applyStimulus(sreq[i], i == 5, 1'b0, 32'h0);
    waitFinished();

    $display("[TB] address wrap");
    startProgram(10'h3FE);
    for (int i = 0; i < 3; i++)
      applyStimulus(mkReq(3, i, i + 1, 0, 0, 0, 0, 16'h100 + i), i == 2, 1'b0, 32'h0);
    waitFinished();

    $display("[TB] illegal request handling");
    startProgram(10'h200);
    applyStimulus(mkReq(1, 2, 3, 4, 1, 0, 0, 0), 1'b0, 1'b0, 32'h0);
    checkOutput("err_after_alu_reg_func1", err, model_err);
    applyStimulus(mkReq(1, 2, 3, 4, 4, 0, 0, 0), 1'b0, 1'b0, 32'h0);
    endProgram();
    waitFinished();
    startProgram(10'h000);
    endProgram();
    waitFinished();

    $display("[TB] reset mid-program");
    startProgram(10'h100);
    setReady(0);
    applyStimulus(mkReq(0, 1, 1, 1, 1, 0, 0, 1), 1'b0, 1'b0, 32'h0);
    applyStimulus(mkReq(0, 2, 2, 2, 2, 0, 0, 2), 1'b0, 1'b0, 32'h0);
    checkOutput("pre_reset_mem_we", mem_we, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
    checkOutput("rst_mem_we", mem_we, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_finished", finished, 0);
    setReady(1);
    repeat (3) tick();
    checkOutput("rst_no_writes", mem_we, 0);
    checkOutput("rst_in_ready", in_ready, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
